clk_div_gen: RTL and testbench

- Parametrised successor to the fixed CPU clock divider.
- Provides:
  - a free-running divide counter;
  - a CPU clock with four run-time modes: fast tap, slow tap, programmable divide, single-step;
  - glitch-free mode switching;
  - a CPU-clock edge pulse and a cycle counter.
- Sits between the board oscillator/switches and the CPU core, display and debug logic.

---
 rtl/clk_div_gen.sv | 182 ++++++++++++++++++
 tb/tb_clk_div_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// clk_div_gen -- CPU clock generator placed between the board oscillator and
// the CPU core. It has a free-running divide counter and a registered CPU
// clock with four run-time modes:
//   0 fast tap   : Clk_CPU follows clkdiv[FAST_TAP]
//   1 slow tap   : Clk_CPU follows clkdiv[SLOW_TAP]
//   2 programmed : half period of (div_lat + 1) clk cycles
//   3 single-step: one high pulse of 2^FAST_TAP clk cycles per step button edge
// A mode change takes effect only while Clk_CPU is low, so the CPU never
// sees a runt pulse when the mode changes.
//
// Ports:
//   clk      in   system clock; all logic runs on its rising edge
//   rst      in   asynchronous active-low reset
//   mode     in   requested mode (0..3)
//   div_val  in   mode-2 half period minus one
//   step     in   asynchronous step button, synchronised internally
//   clkdiv   out  free-running counter
//   Clk_CPU  out  registered CPU clock
//   cpu_en   out  one-cycle pulse on each Clk_CPU 0->1 transition
//   num      out  count of Clk_CPU rising transitions
//   mode_act out  mode currently in effect
//
// Optional feature: define CLK_DIV_NUM_SAT_EN to make num saturate at
// all-ones. When it is not defined, num wraps to zero.
module clk_div_gen #(
  parameter int CNT_W    = 32,
  parameter int FAST_TAP = 2,
  parameter int SLOW_TAP = 24,
  parameter int DIV_W    = 16,
  parameter int NUM_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             step,
  output logic [CNT_W-1:0] clkdiv,
  output logic             Clk_CPU,
  output logic             cpu_en,
  output logic [NUM_W-1:0] num,
  output logic [1:0]       mode_act
);

  typedef enum logic [1:0] {
    MODE_FAST = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_PROG = 2'd2,
    MODE_STEP = 2'd3
  } mode_e;

  localparam int SC_W = (FAST_TAP > 0) ? FAST_TAP : 1;
  localparam logic [SC_W-1:0] STEP_LAST = SC_W'((2 ** FAST_TAP) - 1);

  logic [CNT_W-1:0] r_clkdiv, w_clkdiv_next;
  logic             r_clk_cpu, w_clk_cpu_next;
  logic             r_cpu_en;
  logic [NUM_W-1:0] r_num, w_num_next;
  mode_e            r_mode_act, w_mode_act_next;
  logic [DIV_W-1:0] r_pcnt, w_pcnt_next;
  logic [DIV_W-1:0] r_div_lat, w_div_lat_next;
  logic [SC_W-1:0]  r_step_cnt, w_step_cnt_next;
  logic             r_step_s1, r_step_s2, r_step_s3;
  logic             r_step_busy, w_step_busy_next;
  logic             r_arm, w_arm_next;
  logic             w_step_edge;
  logic             w_tap;
  logic             w_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clkdiv    <= '0;
      r_clk_cpu   <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_num       <= '0;
      r_mode_act  <= MODE_FAST;
      r_pcnt      <= '0;
      r_div_lat   <= '0;
      r_step_cnt  <= '0;
      r_step_s1   <= 1'b0;
      r_step_s2   <= 1'b0;
      r_step_s3   <= 1'b0;
      r_step_busy <= 1'b0;
      r_arm       <= 1'b1;
    end else begin
      r_clkdiv    <= w_clkdiv_next;
      r_clk_cpu   <= w_clk_cpu_next;
      r_cpu_en    <= w_rise;
      r_num       <= w_num_next;
      r_mode_act  <= w_mode_act_next;
      r_pcnt      <= w_pcnt_next;
      r_div_lat   <= w_div_lat_next;
      r_step_cnt  <= w_step_cnt_next;
      r_step_s1   <= step;
      r_step_s2   <= r_step_s1;
      r_step_s3   <= r_step_s2;
      r_step_busy <= w_step_busy_next;
      r_arm       <= w_arm_next;
    end
  end

  always_comb begin
    w_clkdiv_next    = r_clkdiv + CNT_W'(1);
    w_clk_cpu_next   = r_clk_cpu;
    w_mode_act_next  = r_mode_act;
    w_pcnt_next      = r_pcnt;
    w_div_lat_next   = r_div_lat;
    w_step_cnt_next  = r_step_cnt;
    w_step_busy_next = r_step_busy;
    w_arm_next       = r_arm;
    w_step_edge      = r_step_s2 & ~r_step_s3;
    w_tap            = (r_mode_act == MODE_FAST) ? r_clkdiv[FAST_TAP] : r_clkdiv[SLOW_TAP];

    if ((mode != r_mode_act) && !r_clk_cpu) begin
      // Switch only while the clock is low. That low level is held for at
      // least this edge, and every mode starts again from a clean state.
      w_mode_act_next  = mode_e'(mode);
      w_clk_cpu_next   = 1'b0;
      w_pcnt_next      = '0;
      w_div_lat_next   = div_val;
      w_step_busy_next = 1'b0;
      w_arm_next       = 1'b0;
    end else begin
      case (r_mode_act)
        MODE_FAST, MODE_SLOW: begin
          // Wait for the tap bit to be seen low before tracking it. If the
          // clock followed the tap at once, a switch landing in the middle
          // of the tap's high half would give a short high pulse.
          if (r_arm) begin
            w_clk_cpu_next = w_tap;
          end else begin
            w_clk_cpu_next = 1'b0;
            w_arm_next     = ~w_tap;
          end
        end
        MODE_PROG: begin
          if (r_pcnt == r_div_lat) begin
            w_clk_cpu_next = ~r_clk_cpu;
            w_pcnt_next    = '0;
            // Take the new divisor only at the falling toggle, so every
            // period is a whole high/low pair of one length.
            if (r_clk_cpu) w_div_lat_next = div_val;
          end else begin
            w_pcnt_next = r_pcnt + DIV_W'(1);
          end
        end
        default: begin
          if (r_step_busy) begin
            if (r_clk_cpu) begin
              if (r_step_cnt == STEP_LAST) w_clk_cpu_next = 1'b0;
              else                         w_step_cnt_next = r_step_cnt + SC_W'(1);
            end else begin
              // Busy clears one edge after the fall. A step edge that
              // arrives before then is dropped, not queued.
              w_step_busy_next = 1'b0;
            end
          end else if (w_step_edge && !r_clk_cpu) begin
            w_clk_cpu_next   = 1'b1;
            w_step_busy_next = 1'b1;
            w_step_cnt_next  = '0;
          end
        end
      endcase
    end

    w_rise     = w_clk_cpu_next & ~r_clk_cpu;
    w_num_next = r_num;
    if (w_rise) begin
`ifdef CLK_DIV_NUM_SAT_EN
      if (r_num != {NUM_W{1'b1}}) w_num_next = r_num + NUM_W'(1);
`else
      w_num_next = r_num + NUM_W'(1);
`endif
    end
  end

  assign clkdiv   = r_clkdiv;
  assign Clk_CPU  = r_clk_cpu;
  assign cpu_en   = r_cpu_en;
  assign num      = r_num;
  assign mode_act = r_mode_act;

endmodule

// File: tb/tb_clk_div_gen.sv
// Testbench for clk_div_gen. A behavioural model inside the bench is
// compared with every output on each falling clock edge. The bench also
// measures periods, pulse widths and counts for the directed scenarios,
// and then runs a randomised mode/divisor/step phase.
module tb_clk_div_gen;
  localparam int CNT_W    = 8;
  localparam int FAST_TAP = 2;
  localparam int SLOW_TAP = 5;
  localparam int DIV_W    = 8;
  localparam int NUM_W    = 4;
  localparam int CNT_MOD  = 1 << CNT_W;
  localparam int NUM_MAX  = (1 << NUM_W) - 1;
  localparam int STEP_LEN = 1 << FAST_TAP;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div_val;
  logic             step;
  logic [CNT_W-1:0] clkdiv;
  logic             Clk_CPU;
  logic             cpu_en;
  logic [NUM_W-1:0] num;
  logic [1:0]       mode_act;

  clk_div_gen #(
    .CNT_W(CNT_W), .FAST_TAP(FAST_TAP), .SLOW_TAP(SLOW_TAP),
    .DIV_W(DIV_W), .NUM_W(NUM_W)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .div_val(div_val), .step(step),
    .clkdiv(clkdiv), .Clk_CPU(Clk_CPU), .cpu_en(cpu_en), .num(num),
    .mode_act(mode_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: phase lengths count down and the history of the step
  // samples is kept, instead of copying the design's counters.
  int m_cnt, m_num, m_mact, m_rem, m_len, m_hrem;
  bit m_clk, m_en, m_arm, m_busy;
  bit m_s[3];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_num = 0; m_mact = 0; m_rem = 0; m_len = 0; m_hrem = 0;
    m_clk = 0; m_en = 0; m_arm = 1; m_busy = 0;
    for (int k = 0; k < 3; k++) m_s[k] = 0;
  endtask

  task automatic model_step();
    bit nclk;
    bit edge_seen;
    int tap_bit;
    nclk      = m_clk;
    edge_seen = m_s[1] && !m_s[2];
    if (int'(mode) != m_mact && !m_clk) begin
      m_mact = int'(mode);
      nclk   = 0;
      m_arm  = 0;
      m_busy = 0;
      m_len  = int'(div_val) + 1;
      m_rem  = m_len;
    end else begin
      case (m_mact)
        0, 1: begin
          tap_bit = (m_cnt >> ((m_mact == 0) ? FAST_TAP : SLOW_TAP)) & 1;
          if (m_arm) nclk = (tap_bit == 1);
          else begin
            nclk = 0;
            if (tap_bit == 0) m_arm = 1;
          end
        end
        2: begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_clk) m_len = int'(div_val) + 1;
            nclk  = !m_clk;
            m_rem = m_len;
          end
        end
        default: begin
          if (m_busy) begin
            if (m_clk) begin
              m_hrem--;
              if (m_hrem == 0) nclk = 0;
            end else m_busy = 0;
          end else if (edge_seen && !m_clk) begin
            nclk   = 1;
            m_busy = 1;
            m_hrem = STEP_LEN;
          end
        end
      endcase
    end
    m_en = nclk && !m_clk;
    if (m_en) begin
`ifdef CLK_DIV_NUM_SAT_EN
      if (m_num < NUM_MAX) m_num = m_num + 1;
`else
      m_num = (m_num + 1) % (NUM_MAX + 1);
`endif
    end
    m_clk  = nclk;
    m_cnt  = (m_cnt + 1) % CNT_MOD;
    m_s[2] = m_s[1];
    m_s[1] = m_s[0];
    m_s[0] = step;
  endtask

  always @(posedge clk) if (rst) model_step();

  task automatic tick();
    @(negedge clk);
    check_val("clkdiv",   32'(clkdiv),   32'(m_cnt));
    check_val("Clk_CPU",  32'(Clk_CPU),  32'(m_clk));
    check_val("cpu_en",   32'(cpu_en),   32'(m_en));
    check_val("num",      32'(num),      32'(m_num));
    check_val("mode_act", 32'(mode_act), 32'(m_mact));
  endtask

  // Assert reset between clock edges and check that the outputs clear at
  // once, then release it on a falling edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check_val("rst_clkdiv",   32'(clkdiv),   0);
    check_val("rst_Clk_CPU",  32'(Clk_CPU),  0);
    check_val("rst_cpu_en",   32'(cpu_en),   0);
    check_val("rst_num",      32'(num),      0);
    check_val("rst_mode_act", 32'(mode_act), 0);
    model_reset();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_rise(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!cpu_en && cycles < budget);
    if (!cpu_en) check_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic measure_high(input string tag, input int budget, output int n);
    n = 1;
    forever begin
      tick();
      if (!Clk_CPU) break;
      n++;
      if (n > budget) begin
        check_val({tag, "_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  task automatic first_rise_check(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!Clk_CPU && n < 20);
    check_val(tag, n, 5);
  endtask

  initial begin
    int c;
    int h;
    rst = 1'b0; mode = 2'd0; div_val = '0; step = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b1;

    // Fast tap after reset: first rise on the 5th edge, 4 high / 4 low.
    first_rise_check("first_rise");
    measure_high("tap_high", 20, h);
    check_val("tap_high", h, 4);
    wait_rise("tap_low", 20, c);
    check_val("tap_low", c, 4);
    wait_rise("tap_period", 20, c);
    check_val("tap_period", c, 8);
    check_val("num_3rises", 32'(num), 3);

    // Programmable divide.
    mode = 2'd2; div_val = 8'd3;
    wait_rise("prog_sync", 40, c);
    wait_rise("prog_period", 40, c);
    check_val("prog_period", c, 8);
    measure_high("prog_high", 20, h);
    check_val("prog_high", h, 4);
    wait_rise("prog_sync2", 20, c);
    tick();
    div_val = 8'd1;
    // The high phase in progress keeps its length of 4. The low phase
    // that follows is 2. The count starts one tick after the rise.
    wait_rise("prog_change", 20, c);
    check_val("prog_change", c, 5);
    wait_rise("prog_period4", 20, c);
    check_val("prog_period4", c, 4);
    div_val = 8'd0;
    wait_rise("prog_sync3", 20, c);
    wait_rise("prog_sync4", 20, c);
    wait_rise("prog_period2", 20, c);
    check_val("prog_period2", c, 2);

    // Single-step.
    mode = 2'd3;
    tick();
    do_reset();
    step = 1'b1;
    wait_rise("step1", 20, c);
    measure_high("step_high", 20, h);
    check_val("step_high", h, STEP_LEN);
    repeat (14) tick();
    step = 1'b0;
    repeat (6) tick();
    check_val("step_num1", 32'(num), 1);
    step = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1;            // a second edge that arrives during the high phase
    repeat (20) tick();
    step = 1'b0;
    repeat (6) tick();
    check_val("step_drop", 32'(num), 2);
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      repeat (3) tick();
      step = 1'b0;
      repeat (10) tick();
    end
    check_val("step_two", 32'(num), 4);

    // Request a switch from mode 0 to mode 1 while the clock is high.
    mode = 2'd0;
    do_reset();
    wait_rise("sw_rise", 20, c);
    tick();
    mode = 2'd1;
    h = 0;
    while (Clk_CPU && h < 20) begin
      tick();
      h++;
    end
    check_val("sw_hold", 32'(mode_act), 0);
    tick();
    check_val("sw_take", 32'(mode_act), 1);
    wait_rise("slow_rise", 200, c);
    measure_high("slow_high", 100, h);
    check_val("slow_high", h, 1 << SLOW_TAP);

    // Reset asserted while the clock is high, then the first scenario again.
    mode = 2'd0;
    wait_rise("mid_rise", 200, c);
    tick();
    do_reset();
    first_rise_check("first_rise_again");

    // Wrap or saturation of the cycle counter.
    mode = 2'd2; div_val = 8'd0;
    tick();
    do_reset();
    for (int k = 0; k < 20; k++) wait_rise("num20", 20, c);
`ifdef CLK_DIV_NUM_SAT_EN
    check_val("num_20rises", 32'(num), NUM_MAX);
`else
    check_val("num_20rises", 32'(num), 20 % (NUM_MAX + 1));
`endif

    // Randomised mode, divisor and step activity.
    for (int i = 0; i < 2500; i++) begin
      tick();
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) div_val = DIV_W'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) step = ~step;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
